// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract unit: FSM states,
// default field widths, flag positions and the canonical quiet NaN.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT
  } state_e;

  // Bit positions inside output_flags = {invalid, overflow, inexact}
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for fp_addsub: two strobed operand ports
// and one strobed result port.
interface fp_addsub_if
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic         input_op;
  logic [W-1:0] input_b;
  logic         input_b_stb;
  logic         input_b_ack;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;
  logic [2:0]   output_flags;

  modport slave (
    input  input_a, input_a_stb, input_op, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );

  modport master (
    output input_a, input_a_stb, input_op, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input yields W.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);
  // NOTE: assigning a default before the loop keeps this block purely
  // combinational; a path with no assignment would infer a latch.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, one step per
// FSM state; special operands traverse the same states for fixed latency.
module fp_addsub
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic        clk,
  input logic        rst,
  fp_addsub_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;   // significand with hidden bit
  localparam int EW  = EXP_W + 1;   // headroom for exponent carry
  localparam int X   = M + 3;       // significand + guard/round/sticky
  localparam int LZW = $clog2(X + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [M-1:0]  sig;
    logic          nan;
    logic          snan;
    logic          inf;
  } opnd_t;

  function automatic opnd_t unpack(input logic [W-1:0] v, input logic flip);
    opnd_t             o;
    logic [EXP_W-1:0]  ef;
    logic [MAN_W-1:0]  mf;
    ef     = v[W-2 -: EXP_W];
    mf     = v[MAN_W-1:0];
    o.s    = v[W-1] ^ flip;
    o.e    = (ef == '0) ? EW'(1) : {1'b0, ef};
    o.sig  = {ef != '0, mf};
    o.nan  = (ef == EMAX) && (mf != '0);
    o.snan = o.nan && !mf[MAN_W-1];
    o.inf  = (ef == EMAX) && (mf == '0);
    return o;
  endfunction

  state_e       state_q;
  logic         a_ack_q, b_ack_q, z_stb_q;
  logic [W-1:0] z_q;
  logic [2:0]   flags_q;

  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  opnd_t         ua_q, ub_q;
  logic          special_q, special_inv_q;
  logic [W-1:0]  special_z_q;
  logic          big_s_q, small_s_q, sign_q, inexact_q;
  logic [M-1:0]  big_sig_q, small_sig_q, man_q;
  logic [EW-1:0] diff_q, exp_q;
  logic [X-1:0]  small_ext_q, norm_q;
  logic [X:0]    sum_q;

  logic            a_xfer, b_xfer, z_xfer;
  logic            a_big, inf_inf, spec_nan_d, spec_inv_d, special_d;
  logic [W-1:0]    special_z_d, z_d;
  logic [EW-1:0]   shamt, lz_ext, lim, lshift, norm_exp_d, round_exp_d;
  logic [2*M+1:0]  shifted;
  logic [X-1:0]    small_ext_d, norm_d;
  logic [X:0]      sum_d;
  logic            sign_d, rup;
  logic [LZW-1:0]  lz;
  logic [M:0]      man_r;
  logic [M-1:0]    man_d;
  logic [2:0]      flags_d;

  assign a_xfer = (state_q == GET_A) && a_ack_q && bus.input_a_stb;
  assign b_xfer = (state_q == GET_B) && b_ack_q && bus.input_b_stb;
  assign z_xfer = (state_q == PUT) && z_stb_q && bus.output_z_ack;

  fp_lzc #(.W(X)) u_lzc (.in_i(sum_q[X-1:0]), .cnt_o(lz));

  always_comb begin
    special_z_d = QNAN;
    norm_d      = '0;
    norm_exp_d  = exp_q;
    man_d       = '0;
    round_exp_d = exp_q;
    z_d         = '0;
    flags_d     = '0;

    a_big      = {ua_q.e, ua_q.sig} >= {ub_q.e, ub_q.sig};
    inf_inf    = ua_q.inf && ub_q.inf && (ua_q.s != ub_q.s);
    spec_nan_d = ua_q.nan || ub_q.nan || inf_inf;
    spec_inv_d = ua_q.snan || ub_q.snan || inf_inf;
    special_d  = spec_nan_d || ua_q.inf || ub_q.inf;
    if (!spec_nan_d) begin
      special_z_d = ua_q.inf ? {ua_q.s, EMAX, {MAN_W{1'b0}}}
                             : {ub_q.s, EMAX, {MAN_W{1'b0}}};
    end

    // Shifts beyond M+2 only ever feed the sticky bit, so saturate there.
    shamt       = (diff_q > EW'(M + 2)) ? EW'(M + 2) : diff_q;
    shifted     = {small_sig_q, {(M+2){1'b0}}} >> shamt;
    small_ext_d = {shifted[2*M+1:M], |shifted[M-1:0]};

    sum_d  = (big_s_q == small_s_q) ? {1'b0, big_sig_q, 3'b000} + {1'b0, small_ext_q}
                                    : {1'b0, big_sig_q, 3'b000} - {1'b0, small_ext_q};
    sign_d = (sum_d == '0) ? (big_s_q && small_s_q) : big_s_q;

    lz_ext = EW'(lz);
    lim    = exp_q - EW'(1);
    lshift = (lz_ext < lim) ? lz_ext : lim;
    if (sum_q[X]) begin
      norm_d     = {sum_q[X:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + EW'(1);
    end else begin
      norm_d     = sum_q[X-1:0] << lshift;
      norm_exp_d = exp_q - lshift;
    end

    rup   = norm_q[2] && (norm_q[1] || norm_q[0] || norm_q[3]);
    man_r = {1'b0, norm_q[X-1:3]} + {{M{1'b0}}, rup};
    if (man_r[M]) begin
      man_d       = man_r[M:1];
      round_exp_d = exp_q + EW'(1);
    end else begin
      man_d = man_r[M-1:0];
    end

    if (special_q) begin
      z_d                   = special_z_q;
      flags_d[FLAG_INVALID] = special_inv_q;
    end else if (exp_q >= {1'b0, EMAX}) begin
      z_d                    = {sign_q, EMAX, {MAN_W{1'b0}}};
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
    end else begin
      z_d = {sign_q, (man_q[M-1] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}}), man_q[MAN_W-1:0]};
      flags_d[FLAG_INEXACT] = inexact_q;
    end
  end

  // NOTE: datapath registers carry no reset; the FSM alone decides when their
  // contents are meaningful, so resetting them would only add fan-out on rst.
  always_ff @(posedge clk) begin
    unique case (state_q)
      GET_A:   if (a_xfer) begin a_q <= bus.input_a; op_q <= bus.input_op; end
      GET_B:   if (b_xfer) b_q <= bus.input_b;
      UNPACK: begin
        ua_q <= unpack(a_q, 1'b0);
        ub_q <= unpack(b_q, op_q);
      end
      SPECIAL: begin
        special_q     <= special_d;
        special_z_q   <= special_z_d;
        special_inv_q <= spec_inv_d;
        big_s_q       <= a_big ? ua_q.s   : ub_q.s;
        big_sig_q     <= a_big ? ua_q.sig : ub_q.sig;
        small_s_q     <= a_big ? ub_q.s   : ua_q.s;
        small_sig_q   <= a_big ? ub_q.sig : ua_q.sig;
        exp_q         <= a_big ? ua_q.e   : ub_q.e;
        diff_q        <= a_big ? ua_q.e - ub_q.e : ub_q.e - ua_q.e;
      end
      ALIGN:   small_ext_q <= small_ext_d;
      ADD:     begin sum_q <= sum_d; sign_q <= sign_d; end
      NORM: begin
        norm_q    <= norm_d;
        exp_q     <= norm_exp_d;
        inexact_q <= |norm_d[2:0];
      end
      ROUND:   begin man_q <= man_d; exp_q <= round_exp_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      unique case (state_q)
        GET_A: begin
          if (a_xfer) begin
            state_q <= GET_B;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b1;
          end else begin
            a_ack_q <= 1'b1;
          end
        end
        GET_B:   if (b_xfer) begin state_q <= UNPACK; b_ack_q <= 1'b0; end
        UNPACK:  state_q <= SPECIAL;
        SPECIAL: state_q <= ALIGN;
        ALIGN:   state_q <= ADD;
        ADD:     state_q <= NORM;
        NORM:    state_q <= ROUND;
        ROUND:   state_q <= PACK;
        PACK: begin
          state_q <= PUT;
          z_q     <= z_d;
          flags_q <= flags_d;
          z_stb_q <= 1'b1;
        end
        PUT: begin
          if (z_xfer) begin
            state_q <= GET_A;
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b1;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign bus.input_a_ack  = a_ack_q;
  assign bus.input_b_ack  = b_ack_q;
  assign bus.output_z     = z_q;
  assign bus.output_z_stb = z_stb_q;
  assign bus.output_flags = flags_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: expected results queued at stimulus time and
// compared when the result strobe appears.
module tb_fp_addsub;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_addsub #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] z;
    logic [2:0]  f;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/z"},     bus.output_z, 32'h0);
    check({tag, "/z_stb"}, 32'(bus.output_z_stb), 32'd0);
    check({tag, "/flags"}, 32'(bus.output_flags), 32'd0);
    check({tag, "/a_ack"}, 32'(bus.input_a_ack), 32'd0);
    check({tag, "/b_ack"}, 32'(bus.input_b_ack), 32'd0);
  endtask

  task automatic drive_a(input logic [31:0] a, input logic op, input string tag);
    bit seen = 1'b0;
    @(negedge clk);
    bus.input_a     = a;
    bus.input_op    = op;
    bus.input_a_stb = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.input_a_ack) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "/a_ack"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1 bus.input_a_stb = 1'b0;
  endtask

  task automatic drive_b(input logic [31:0] b, input string tag);
    bit seen = 1'b0;
    @(negedge clk);
    bus.input_b     = b;
    bus.input_b_stb = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.input_b_ack) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "/b_ack"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1 bus.input_b_stb = 1'b0;
  endtask

  // Full transaction; result must appear 7 edges after the B transfer and,
  // when hold > 0, stay stable while the consumer withholds its ack.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] ez, input logic [2:0] ef,
                       input string tag, input int hold);
    exp_t e;
    int   lat = -1;
    e.z = ez; e.f = ef; e.tag = tag;
    sb_q.push_back(e);
    drive_a(a, op, tag);
    drive_b(b, tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.output_z_stb) begin lat = k; break; end
    end
    check({tag, "/latency"}, 32'(lat), 32'd7);
    e = sb_q.pop_front();
    check({e.tag, "/z"},     bus.output_z, e.z);
    check({e.tag, "/flags"}, 32'(bus.output_flags), 32'(e.f));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({e.tag, "/hold_z"},     bus.output_z, e.z);
      check({e.tag, "/hold_flags"}, 32'(bus.output_flags), 32'(e.f));
      check({e.tag, "/hold_stb"},   32'(bus.output_z_stb), 32'd1);
      check({e.tag, "/hold_a_ack"}, 32'(bus.input_a_ack), 32'd0);
      check({e.tag, "/hold_b_ack"}, 32'(bus.input_b_ack), 32'd0);
    end
    bus.output_z_ack = 1'b1;
    @(negedge clk);
    bus.output_z_ack = 1'b0;
    check({tag, "/a_ack_after_put"}, 32'(bus.input_a_ack), 32'd1);
    check({tag, "/stb_after_put"},   32'(bus.output_z_stb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.input_a      = '0;
    bus.input_a_stb  = 1'b0;
    bus.input_op     = 1'b0;
    bus.input_b      = '0;
    bus.input_b_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    rst              = 1'b1;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset/a_ack_rise", 32'(bus.input_a_ack), 32'd1);

    apply(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, "1p2", 0);
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, "1m1", 0);
    apply(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b000, "nz_m_pz", 0);
    apply(32'h7F80_0000, 32'h7F80_0000, 1'b1, QNAN_SP,       3'b100, "inf_m_inf", 0);
    apply(32'h7FC0_0000, 32'h3F80_0000, 1'b0, QNAN_SP,       3'b000, "qnan_p1", 0);
    apply(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b011, "overflow", 5);
    apply(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b001, "tie_even", 0);
    apply(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 3'b000, "subn_add", 0);
    apply(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 3'b001, "round_up", 0);
    apply(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 3'b001, "tie_odd_up", 0);
    apply(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 3'b000, "cancel", 0);
    apply(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000, "1m2", 0);
    apply(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 3'b000, "inf_p1", 0);
    apply(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000, "1m_inf", 0);
    apply(32'h7F80_0001, 32'h3F80_0000, 1'b0, QNAN_SP,       3'b100, "snan_p1", 0);
    apply(32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF, 3'b000, "to_subn", 0);
    apply(32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000, 3'b001, "sticky_only", 0);
    apply(32'hC000_0000, 32'hC040_0000, 1'b0, 32'hC0A0_0000, 3'b000, "neg_add", 0);

    // Abort an operation while it sits in ALIGN.
    drive_a(32'h3F80_0000, 1'b0, "abort");
    drive_b(32'h4000_0000, "abort");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort_rst");
    rst = 1'b0;
    @(negedge clk);
    check("abort/a_ack_rise", 32'(bus.input_a_ack), 32'd1);
    check("abort/no_result",  32'(bus.output_z_stb), 32'd0);

    apply(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, "after_abort", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
